// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the LED sweep controller.
// Holds the state and opcode encodings plus the brightness step size.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_LOAD  = 2'd3
    } state_e;

    localparam logic [1:0] OP_STOP       = 2'd0;
    localparam logic [1:0] OP_RUN        = 2'd1;
    localparam logic [1:0] OP_SET_PERIOD = 2'd2;
    localparam logic [1:0] OP_SET_ALL    = 2'd3;

    localparam int LEVEL_STEP = 32;
    localparam int N_LEDS     = 8;

endpackage

// File: rtl/led_sweep_ctrl_if.sv
// Command channel from the remote decoder: valid/ready handshake with opcode and operand.
interface led_sweep_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_arg;

    modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/led_sweep_ctrl_pwm_bank.sv
// Eight-entry brightness register file with one write port and a shared
// free-running PWM counter; each LED output is registered.
module pwm_bank
    import led_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [2:0] idx,
    input  logic [7:0] val,
    output logic [7:0] leds
);

    logic [7:0] bright_q [N_LEDS];
    logic [7:0] bright_d [N_LEDS];
    logic [7:0] pwm_cnt_q, pwm_cnt_d;
    logic [7:0] leds_q, leds_d;

    always_comb begin
        bright_d  = bright_q;
        pwm_cnt_d = pwm_cnt_q + 8'd1;
        leds_d    = '0;
        if (we) begin
            bright_d[idx] = val;
        end
        // Strict compare: level 0 never lights, level 255 misses one slot of 256.
        for (int i = 0; i < N_LEDS; i++) begin
            leds_d[i] = (pwm_cnt_q < bright_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_LEDS; i++) begin
                bright_q[i] <= '0;
            end
            pwm_cnt_q <= '0;
            leds_q    <= '0;
        end else begin
            bright_q  <= bright_d;
            pwm_cnt_q <= pwm_cnt_d;
            leds_q    <= leds_d;
        end
    end

    assign leds = leds_q;

endmodule

// File: rtl/led_sweep_ctrl.sv
// Host-commanded LED sequencer: timed fill/drain sweep, freeze, programmable
// step period and bulk brightness load, feeding the PWM bank.
module led_sweep_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int CLK_FREQ       = 25_000_000,
    parameter int UNIT_TICKS     = CLK_FREQ / 100,
    parameter int DEFAULT_PERIOD = 200
) (
    input  logic                   clk,
    input  logic                   rst,
    led_sweep_ctrl_if.slave        cmd,
    output logic [7:0]             leds,
    output logic                   busy,
    output logic [1:0]             phase,
    output logic [2:0]             step_idx
);

    localparam int TICK_W = (UNIT_TICKS > 1) ? $clog2(UNIT_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(UNIT_TICKS - 1);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_FILL  = ST_FILL;
    localparam logic [1:0] S_DRAIN = ST_DRAIN;
    localparam logic [1:0] S_LOAD  = ST_LOAD;

    logic [1:0]        state_q, state_d;
    logic [2:0]        step_idx_q, step_idx_d;
    logic [7:0]        period_q, period_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [7:0]        unit_cnt_q, unit_cnt_d;
    logic [7:0]        load_lvl_q, load_lvl_d;
    logic [2:0]        load_idx_q, load_idx_d;

    logic       accept, running, tick_wrap, step_evt;
    logic [7:0] eff_period;
    logic       wr_en;
    logic [2:0] wr_idx;
    logic [7:0] wr_val;

    function automatic logic [7:0] sat_level(input logic [8:0] v);
        return (v > 9'd255) ? 8'd255 : v[7:0];
    endfunction

    assign cmd.cmd_ready = (state_q != S_LOAD);
    assign accept        = cmd.cmd_valid & cmd.cmd_ready;
    assign running       = (state_q == S_FILL) || (state_q == S_DRAIN);
    assign eff_period    = (period_q == 8'd0) ? 8'd1 : period_q;
    assign tick_wrap     = (tick_cnt_q == TICK_LAST);
    assign step_evt      = running && tick_wrap && (unit_cnt_q == eff_period - 8'd1);

    always_comb begin
        state_d    = state_q;
        step_idx_d = step_idx_q;
        period_d   = period_q;
        tick_cnt_d = tick_cnt_q;
        unit_cnt_d = unit_cnt_q;
        load_lvl_d = load_lvl_q;
        load_idx_d = load_idx_q;
        wr_en      = 1'b0;
        wr_idx     = step_idx_q;
        wr_val     = '0;

        if (running) begin
            tick_cnt_d = tick_wrap ? '0 : tick_cnt_q + TICK_W'(1);
            if (step_evt) begin
                unit_cnt_d = '0;
            end else if (tick_wrap) begin
                unit_cnt_d = unit_cnt_q + 8'd1;
            end
        end

        // Every accepted command restarts the period and pre-empts a coincident step.
        if (accept) begin
            tick_cnt_d = '0;
            unit_cnt_d = '0;
            case (cmd.cmd_op)
                OP_STOP:       state_d = S_IDLE;
                OP_RUN:        if (state_q == S_IDLE) state_d = S_FILL;
                OP_SET_PERIOD: period_d = cmd.cmd_arg;
                default: begin
                    load_lvl_d = cmd.cmd_arg;
                    load_idx_d = '0;
                    state_d    = S_LOAD;
                end
            endcase
        end else if (step_evt) begin
            wr_en      = 1'b1;
            wr_val     = (state_q == S_FILL)
                       ? sat_level(9'((9'(step_idx_q) + 9'd1) * 9'(LEVEL_STEP)))
                       : 8'd0;
            step_idx_d = step_idx_q + 3'd1;
            if (step_idx_q == 3'd7) begin
                state_d = (state_q == S_FILL) ? S_DRAIN : S_FILL;
            end
        end else if (state_q == S_LOAD) begin
            wr_en      = 1'b1;
            wr_idx     = load_idx_q;
            wr_val     = load_lvl_q;
            load_idx_d = load_idx_q + 3'd1;
            if (load_idx_q == 3'd7) begin
                step_idx_d = '0;
                state_d    = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            step_idx_q <= '0;
            period_q   <= 8'(DEFAULT_PERIOD);
            tick_cnt_q <= '0;
            unit_cnt_q <= '0;
            load_lvl_q <= '0;
            load_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            step_idx_q <= step_idx_d;
            period_q   <= period_d;
            tick_cnt_q <= tick_cnt_d;
            unit_cnt_q <= unit_cnt_d;
            load_lvl_q <= load_lvl_d;
            load_idx_q <= load_idx_d;
        end
    end

    pwm_bank u_pwm (
        .clk  (clk),
        .rst  (rst),
        .we   (wr_en),
        .idx  (wr_idx),
        .val  (wr_val),
        .leds (leds)
    );

    assign busy     = (state_q != S_IDLE);
    assign phase    = state_q;
    assign step_idx = step_idx_q;

endmodule
